// File: rtl/reset_sequencer_if.sv
// -----------------------------------------------------------------------------
// reset_sequencer_if
// Groups the board-facing inputs and the core-facing outputs of the reset
// sequencer into one bundle.
//   pll_lock      : PLL lock indication, asynchronous to the sequencer clock
//   btn_n         : user pushbutton, active-low, asynchronous and bouncy
//   cpu_resetn    : active-low reset to the core, high only in RUN
//   state         : sequencer state (HOLD=0, WAIT_LOCK=1, STRETCH=2, RUN=3)
//   lock_lost_cnt : saturating count of lock losses observed in RUN
// modport slave  : the sequencer side
// modport master : the environment side (board / testbench)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface reset_sequencer_if;
    logic       pll_lock;
    logic       btn_n;
    logic       cpu_resetn;
    logic [1:0] state;
    logic [7:0] lock_lost_cnt;

    modport master (
        output pll_lock,
        output btn_n,
        input  cpu_resetn,
        input  state,
        input  lock_lost_cnt
    );

    modport slave (
        input  pll_lock,
        input  btn_n,
        output cpu_resetn,
        output state,
        output lock_lost_cnt
    );
endinterface

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
// Holds the core in reset until the PLL is locked, lock has been stable for
// LOCK_FILTER cycles and a further STRETCH_CYCLES delay has elapsed. A
// debounced pushbutton forces a user reset, and lock loss in RUN drops the
// core back into reset and is counted for debug.
// Ports:
//   clk   : PLL output clock, sole clock
//   reset : asynchronous active-high reset, clears every register
//   bus   : reset_sequencer_if.slave (pll_lock, btn_n in; cpu_resetn,
//           state, lock_lost_cnt out; all outputs are registers)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module reset_sequencer #(
    parameter int LOCK_FILTER     = 16,
    parameter int STRETCH_CYCLES  = 4000,
    parameter int DEBOUNCE_CYCLES = 400000
) (
    input  logic             clk,
    input  logic             reset,
    reset_sequencer_if.slave bus
);

    localparam int FILT_W = $clog2(LOCK_FILTER + 1);
    localparam int STR_W  = $clog2(STRETCH_CYCLES + 1);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
    localparam logic [STR_W-1:0]  STR_LOAD  = STR_W'(STRETCH_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HOLD      = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STRETCH   = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    logic              r_lock_meta;
    logic              r_lock_s;
    logic              r_btn_meta;
    logic              r_btn_s;
    logic              r_btn_db;
    logic [DB_W-1:0]   r_db_cnt;
    logic [FILT_W-1:0] r_filt_cnt;
    logic [FILT_W-1:0] w_filt_next;
    logic [STR_W-1:0]  r_str_cnt;
    logic [STR_W-1:0]  w_str_next;
    state_t            r_state;
    state_t            w_state_next;
    logic              r_cpu_resetn;
    logic              w_cpu_resetn_next;
    logic [7:0]        r_lost_cnt;
    logic [7:0]        w_lost_next;

    // Two-flop synchronizers for the asynchronous lock and (inverted) button.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
            r_btn_meta  <= 1'b0;
            r_btn_s     <= 1'b0;
        end else begin
            r_lock_meta <= bus.pll_lock;
            r_lock_s    <= r_lock_meta;
            r_btn_meta  <= ~bus.btn_n;
            r_btn_s     <= r_btn_meta;
        end
    end

    // Debouncer: the level changes only after DEBOUNCE_CYCLES consecutive
    // mismatching cycles; any agreeing cycle restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btn_db <= 1'b0;
            r_db_cnt <= {DB_W{1'b0}};
        end else if (r_btn_s == r_btn_db) begin
            r_db_cnt <= {DB_W{1'b0}};
        end else if (r_db_cnt == DB_LAST) begin
            r_btn_db <= r_btn_s;
            r_db_cnt <= {DB_W{1'b0}};
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    // State register together with its counters and the registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_HOLD;
            r_cpu_resetn <= 1'b0;
            r_filt_cnt   <= {FILT_W{1'b0}};
            r_str_cnt    <= {STR_W{1'b0}};
            r_lost_cnt   <= 8'd0;
        end else begin
            r_state      <= w_state_next;
            r_cpu_resetn <= w_cpu_resetn_next;
            r_filt_cnt   <= w_filt_next;
            r_str_cnt    <= w_str_next;
            r_lost_cnt   <= w_lost_next;
        end
    end

    // Next-state logic. In STRETCH a lock glitch outranks the button so the
    // sequence restarts from the filter; in RUN the button outranks lock loss.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_HOLD: begin
                if (r_btn_db) begin
                    w_state_next = ST_HOLD;
                end else begin
                    w_state_next = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (r_btn_db) begin
                    w_state_next = ST_HOLD;
                end else if (r_lock_s && (r_filt_cnt == FILT_LAST)) begin
                    w_state_next = ST_STRETCH;
                end else begin
                    w_state_next = ST_WAIT_LOCK;
                end
            end
            ST_STRETCH: begin
                if (!r_lock_s) begin
                    w_state_next = ST_WAIT_LOCK;
                end else if (r_btn_db) begin
                    w_state_next = ST_HOLD;
                end else if (r_str_cnt == {STR_W{1'b0}}) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_STRETCH;
                end
            end
            ST_RUN: begin
                if (r_btn_db) begin
                    w_state_next = ST_HOLD;
                end else if (!r_lock_s) begin
                    w_state_next = ST_WAIT_LOCK;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_HOLD;
            end
        endcase
    end

    // Counter updates. The filter only counts while staying in WAIT_LOCK with
    // lock present, so every entry into WAIT_LOCK starts from zero.
    always_comb begin
        w_filt_next = {FILT_W{1'b0}};
        w_str_next  = {STR_W{1'b0}};
        w_lost_next = r_lost_cnt;

        if ((r_state == ST_WAIT_LOCK) && (w_state_next == ST_WAIT_LOCK) && r_lock_s) begin
            w_filt_next = r_filt_cnt + 1'b1;
        end else begin
            w_filt_next = {FILT_W{1'b0}};
        end

        if (w_state_next == ST_STRETCH) begin
            if (r_state == ST_STRETCH) begin
                w_str_next = r_str_cnt - 1'b1;
            end else begin
                w_str_next = STR_LOAD;
            end
        end else begin
            w_str_next = {STR_W{1'b0}};
        end

        // Lock loss in RUN is counted even when the button wins the transition.
        if ((r_state == ST_RUN) && !r_lock_s && (r_lost_cnt != 8'hFF)) begin
            w_lost_next = r_lost_cnt + 8'd1;
        end else begin
            w_lost_next = r_lost_cnt;
        end
    end

    // Output decode from the next state so cpu_resetn changes with the state.
    always_comb begin
        w_cpu_resetn_next = 1'b0;
        if (w_state_next == ST_RUN) begin
            w_cpu_resetn_next = 1'b1;
        end else begin
            w_cpu_resetn_next = 1'b0;
        end
    end

    assign bus.cpu_resetn    = r_cpu_resetn;
    assign bus.state         = r_state;
    assign bus.lock_lost_cnt = r_lost_cnt;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
// Directed scenarios followed by random lock/button activity. Every cycle the
// DUT outputs are compared against a reference model that tracks the number
// of consecutive locked cycles in the current start attempt rather than
// separate filter/stretch counters.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_reset_sequencer;

    localparam int LF = 4;
    localparam int SC = 8;
    localparam int DB = 5;

    localparam int M_HOLD = 0;
    localparam int M_TRY  = 1;
    localparam int M_RUN  = 2;

    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model state
    int m_l1, m_ls, m_b1, m_bs, m_db, m_mis;
    int m_mode, m_run, m_lost;

    reset_sequencer_if bus ();

    reset_sequencer #(
        .LOCK_FILTER     (LF),
        .STRETCH_CYCLES  (SC),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_l1 = 0; m_ls = 0; m_b1 = 0; m_bs = 0; m_db = 0; m_mis = 0;
        m_mode = M_HOLD; m_run = 0; m_lost = 0;
    endtask

    function automatic int exp_state();
        if (m_mode == M_HOLD) return 0;
        if (m_mode == M_RUN) return 3;
        return (m_run < LF) ? 1 : 2;
    endfunction

    // Advance the model by one clock edge using the inputs about to be sampled.
    task automatic model_step();
        int ls;
        int db;
        if (reset) begin
            model_clear();
            return;
        end
        ls = m_ls;
        db = m_db;
        if (m_bs != m_db) begin
            m_mis++;
            if (m_mis == DB) begin
                m_db  = m_bs;
                m_mis = 0;
            end
        end else begin
            m_mis = 0;
        end
        m_bs = m_b1;
        m_b1 = bus.btn_n ? 0 : 1;
        m_ls = m_l1;
        m_l1 = bus.pll_lock ? 1 : 0;
        case (m_mode)
            M_HOLD: if (db == 0) begin m_mode = M_TRY; m_run = 0; end
            M_TRY: begin
                if (m_run < LF) begin
                    if (db != 0) m_mode = M_HOLD;
                    else if (ls != 0) m_run++;
                    else m_run = 0;
                end else begin
                    if (ls == 0) m_run = 0;
                    else if (db != 0) m_mode = M_HOLD;
                    else begin
                        m_run++;
                        if (m_run == LF + SC) m_mode = M_RUN;
                    end
                end
            end
            default: begin
                if (ls == 0 && m_lost < 255) m_lost++;
                if (db != 0) m_mode = M_HOLD;
                else if (ls == 0) begin m_mode = M_TRY; m_run = 0; end
            end
        endcase
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("state", 32'(bus.state), 32'(exp_state()));
        chk("cpu_resetn", 32'(bus.cpu_resetn), 32'(m_mode == M_RUN));
        chk("lock_lost_cnt", 32'(bus.lock_lost_cnt), 32'(m_lost));
    endtask

    // Wait (bounded) for cpu_resetn; exp_edges > 0 also checks the edge count.
    task automatic wait_release(input int exp_edges, input string tag);
        int n = 0;
        while (bus.cpu_resetn !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        if (exp_edges > 0) chk(tag, 32'(n), 32'(exp_edges));
        else chk(tag, 32'(bus.cpu_resetn), 32'd1);
    endtask

    task automatic wait_state(input int target, input string tag);
        int n = 0;
        while (32'(bus.state) != 32'(target) && n < 300) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.state), 32'(target));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold_left;
        hold_left    = 0;
        reset        = 1'b1;
        bus.pll_lock = 1'b1;
        bus.btn_n    = 1'b1;
        model_clear();
        #1;
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_cpu_resetn", 32'(bus.cpu_resetn), 32'd0);
        chk("rst_lost", 32'(bus.lock_lost_cnt), 32'd0);

        // power-up: release 14 edges after reset release (2 sync + 4 + 8)
        repeat (3) tick();
        reset = 1'b0;
        wait_release(14, "powerup_latency");

        // asynchronous reset between edges while in RUN
        #2;
        reset = 1'b1;
        #1;
        chk("async_state", 32'(bus.state), 32'd0);
        chk("async_cpu_resetn", 32'(bus.cpu_resetn), 32'd0);
        chk("async_lost", 32'(bus.lock_lost_cnt), 32'd0);
        model_clear();
        tick();
        tick();
        reset = 1'b0;

        // one-cycle lock glitch midway through STRETCH restarts the filter
        wait_state(2, "reach_stretch");
        repeat (3) tick();
        bus.pll_lock = 1'b0;
        tick();
        bus.pll_lock = 1'b1;
        wait_release(14, "glitch_relock");
        chk("glitch_lost", 32'(bus.lock_lost_cnt), 32'd0);

        // lock loss in RUN: cpu_resetn drops 3 edges after pll_lock falls
        bus.pll_lock = 1'b0;
        tick();
        bus.pll_lock = 1'b1;
        tick();
        chk("loss_edge2_cpu", 32'(bus.cpu_resetn), 32'd1);
        tick();
        chk("loss_edge3_cpu", 32'(bus.cpu_resetn), 32'd0);
        chk("loss_count", 32'(bus.lock_lost_cnt), 32'd1);
        wait_release(12, "loss_relock");

        // debounce completes in the same cycle lock_s falls in RUN
        bus.btn_n = 1'b0;
        repeat (5) tick();
        bus.pll_lock = 1'b0;
        repeat (2) tick();
        bus.pll_lock = 1'b1;
        tick();
        chk("simul_state", 32'(bus.state), 32'd0);
        chk("simul_lost", 32'(bus.lock_lost_cnt), 32'd2);
        bus.btn_n = 1'b1;
        wait_release(0, "simul_recover");

        // bounce every 2 cycles never debounces
        for (int i = 0; i < 20; i++) begin
            bus.btn_n = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
        end
        bus.btn_n = 1'b1;
        repeat (8) tick();
        chk("bounce_state", 32'(bus.state), 32'd3);

        // clean 7-cycle press: HOLD exactly 8 edges after the press
        bus.btn_n = 1'b0;
        repeat (7) tick();
        chk("press_edge7_state", 32'(bus.state), 32'd3);
        bus.btn_n = 1'b1;
        tick();
        chk("press_edge8_state", 32'(bus.state), 32'd0);
        wait_release(0, "press_recover");

        // repeated lock loss saturates the counter
        for (int i = 0; i < 300; i++) begin
            bus.pll_lock = 1'b0;
            tick();
            bus.pll_lock = 1'b1;
            tick();
            tick();
            wait_release(12, "sat_relock");
        end
        chk("sat_lost", 32'(bus.lock_lost_cnt), 32'd255);

        // random lock drops and button presses of varying length
        for (int c = 0; c < 3000; c++) begin
            if (bus.pll_lock) begin
                if ($urandom_range(0, 59) == 0) bus.pll_lock = 1'b0;
            end else begin
                if ($urandom_range(0, 2) == 0) bus.pll_lock = 1'b1;
            end
            if (hold_left > 0) begin
                bus.btn_n = 1'b0;
                hold_left--;
            end else begin
                bus.btn_n = 1'b1;
                if ($urandom_range(0, 99) == 0) hold_left = int'($urandom_range(1, 9));
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Reset and startup sequencer sitting directly downstream of the board PLL wrapper. It runs on the PLL output clock and holds the RV32I core in reset until three conditions hold: the PLL reports lock, lock has been stable for a filter window, and a stretch delay has elapsed. It also debounces the board pushbutton as a user reset, re-enters reset on PLL lock loss, and counts lock-loss events for debug.

## Interface
Parameters:
- `LOCK_FILTER`, default 16: consecutive synchronized-lock cycles required before the stretch delay starts (≥1).
- `STRETCH_CYCLES`, default 4000: cycles spent in STRETCH before the core is released (≥1); 100 µs at 40 MHz.
- `DEBOUNCE_CYCLES`, default 400000: cycles the button must be stable before its debounced level changes (≥1); 10 ms at 40 MHz.

Ports:
- `clk` in 1: PLL output clock (PLLOUTCORE); sole clock.
- `reset` in 1: asynchronous, active-high reset; clears every register.
- `pll_lock` in 1: PLL LOCK, asynchronous to `clk`.
- `btn_n` in 1: pushbutton, active-low, asynchronous, bouncy.
- `cpu_resetn` out 1: active-low reset to the core; 1 only in RUN.
- `state` out 2: current state: HOLD=0, WAIT_LOCK=1, STRETCH=2, RUN=3.
- `lock_lost_cnt` out 8: saturating count of lock losses seen in RUN.

## Operation
- Synchronizers: `pll_lock` passes through two flops to give `lock_s`. The inverted `btn_n` passes through two flops to give `btn_s` (1 = pressed). Both reset to 0.
- Debouncer:
  - Register `btn_db` (reset 0) and a counter of width clog2(DEBOUNCE_CYCLES+1).
  - When `btn_s == btn_db`, the counter clears.
  - Otherwise the counter increments. In the cycle the counter equals DEBOUNCE_CYCLES-1 with the mismatch still present, `btn_db` takes `btn_s` and the counter clears.
- State machine (registered; reset state HOLD):
  - HOLD: stay while `btn_db=1`; else go to WAIT_LOCK.
  - WAIT_LOCK: the filter counter increments while `lock_s=1` and clears when `lock_s=0`. When the counter equals LOCK_FILTER-1 with `lock_s=1`, go to STRETCH and load the stretch counter with STRETCH_CYCLES-1.
  - STRETCH: the stretch counter decrements each cycle.
    - If `lock_s=0`, go to WAIT_LOCK with the filter cleared.
    - Else if `btn_db=1`, go to HOLD.
    - Else, when the counter is 0, go to RUN.
  - RUN:
    - If `btn_db=1`, go to HOLD (button has priority).
    - Else if `lock_s=0`, go to WAIT_LOCK.
    - In either case, `lock_lost_cnt` increments whenever `lock_s=0` in RUN, saturating at 255.
  - WAIT_LOCK with `btn_db=1` goes to HOLD.
- Outputs: `cpu_resetn` is a flop updated with the state register, 1 iff the next state is RUN. `state` is the state register itself. All outputs are glitch-free registers.
- Counter widths: use clog2 of the parameter + 1; no wrap-around is reachable.

## Timing
- Reset values: `state`=0, `cpu_resetn`=0, `lock_lost_cnt`=0, all counters and synchronizers 0.
- Assertion of `reset` forces these values immediately (asynchronously), including in mid-STRETCH or mid-RUN.
- After `reset` deasserts with the button released, `state` is HOLD for one cycle, then WAIT_LOCK.
- Lock latency:
  - `lock_s` follows `pll_lock` by 2 cycles.
  - The first `lock_s=1` cycle in WAIT_LOCK is filter cycle 0.
  - STRETCH is entered LOCK_FILTER cycles later and lasts exactly STRETCH_CYCLES cycles.
  - So RUN and `cpu_resetn=1` appear LOCK_FILTER+STRETCH_CYCLES cycles after `lock_s` first rises.
- Lock loss: `cpu_resetn` falls on the edge after `lock_s` falls, i.e. 3 cycles after `pll_lock` falls.
- Button: `btn_db` rises DEBOUNCE_CYCLES+2 cycles after a clean press; `cpu_resetn` falls 1 cycle later.
- Any glitch in `lock_s` during the filter window or during STRETCH restarts the full sequence.

## Test plan
Parameters for all scenarios: LOCK_FILTER=4, STRETCH_CYCLES=8, DEBOUNCE_CYCLES=5.
- Power-up: `reset` high for 3 cycles, `pll_lock` tied 1 → `state` goes 0,1,…; `cpu_resetn` rises exactly 12 cycles after the first `lock_s=1`; `lock_lost_cnt`=0.
- Lock glitch: drop `pll_lock` for 1 cycle midway through STRETCH → return to WAIT_LOCK; release occurs 12 cycles after `lock_s` returns; `lock_lost_cnt` stays 0.
- Lock loss in RUN: drop `pll_lock` once → `cpu_resetn`=0 three cycles later; `lock_lost_cnt`=1; re-lock releases after 12 more cycles. Repeat 300 times → saturates at 255.
- Button bounce: toggle `btn_n` every 2 cycles for 20 cycles, then hold high → `btn_db` never rises and `state` stays RUN. Then hold `btn_n` low for 7 cycles → HOLD entered 8 cycles after the press; release → WAIT_LOCK → RUN.
- Simultaneous events: button debounce completes in the same cycle `lock_s` falls in RUN → next state HOLD and `lock_lost_cnt` increments.
- Async reset mid-RUN: assert `reset` between clock edges → `cpu_resetn`=0 and `state`=0 before the next edge; the sequence restarts on release.
